alien_formation_march: RTL

Parametrised marching invader formation; successor to the static formation block. Owns the alive matrix, group position, march timing, edge reversal/descent, hit retirement, level progression and the pixel-hit test against the VGA scan. Sits between the game controller (start, frame ticks, hit reports) and the VGA pixel mux.

---
 rtl/alien_formation_march_if.sv | 43 ++++
 rtl/alien_formation_march.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/alien_formation_march_if.sv
// alien_formation_march_if: controller/VGA-side bundle for the marching formation (master = game controller, slave = formation)
interface alien_formation_march_if #(
  parameter int NUM_ROWS    = 3,
  parameter int NUM_COLUMNS = 5
);
  logic                            frame_tick;
  logic                            start;
  logic                            hit_valid;
  logic [2:0]                      hit_row;
  logic [3:0]                      hit_col;
  logic [15:0]                     scan_x;
  logic [15:0]                     scan_y;
  logic [NUM_ROWS*NUM_COLUMNS-1:0] alive_matrix;
  logic [NUM_ROWS*NUM_COLUMNS-1:0] armed_matrix;
  logic [15:0]                     formation_x;
  logic [15:0]                     formation_y;
  logic [3:0]                      level;
  logic                            hit_accept;
  logic                            cleared;
  logic                            landed;
  logic                            alien_pixel;
`ifdef ALIEN_FORMATION_SHOOTER_EN
  logic                            fire_req;
  logic [15:0]                     fire_x;
  logic [15:0]                     fire_y;
`endif
  modport master (
    output frame_tick, start, hit_valid, hit_row, hit_col, scan_x, scan_y,
    input  alive_matrix, armed_matrix, formation_x, formation_y, level,
           hit_accept, cleared, landed, alien_pixel
`ifdef ALIEN_FORMATION_SHOOTER_EN
    , input fire_req, fire_x, fire_y
`endif
  );
  modport slave (
    input  frame_tick, start, hit_valid, hit_row, hit_col, scan_x, scan_y,
    output alive_matrix, armed_matrix, formation_x, formation_y, level,
           hit_accept, cleared, landed, alien_pixel
`ifdef ALIEN_FORMATION_SHOOTER_EN
    , output fire_req, fire_x, fire_y
`endif
  );
endinterface

// File: rtl/alien_formation_march.sv
// alien_formation_march: marching invader formation (alive matrix, march/descend, hits, levels, pixel test); ports clk, rst_n (async active-low), bus (slave: frame_tick/start/hit_*/scan_* in; alive/armed matrices, formation_x/y, level, hit_accept, cleared, landed, alien_pixel out); optional shooter via ALIEN_FORMATION_SHOOTER_EN
module alien_formation_march #(
  parameter int NUM_ROWS    = 3,
  parameter int NUM_COLUMNS = 5,
  parameter int SPACING_X   = 64,
  parameter int SPACING_Y   = 32,
  parameter int ALIEN_W     = 32,
  parameter int ALIEN_H     = 16,
  parameter int START_X     = 100,
  parameter int START_Y     = 50,
  parameter int STEP_X      = 4,
  parameter int STEP_Y      = 16,
  parameter int LEFT_BOUND  = 0,
  parameter int RIGHT_BOUND = 639,
  parameter int LAND_Y      = 400,
  parameter int BASE_PERIOD = 30,
  parameter int MIN_PERIOD  = 2
) (
  input logic clk,
  input logic rst_n,
  alien_formation_march_if.slave bus
);
  localparam int N = NUM_ROWS * NUM_COLUMNS;
  typedef enum logic [1:0] {IDLE, MARCH, CLEARED, LANDED} state_t;
  state_t state;
  logic [N-1:0] alive, armed, hit_mask;
  logic [15:0] fx, fy, cnt, kills;
  logic [3:0] lvl, lcol, rcol;
  logic [2:0] brow;
  logic dir_left, below, pix, hit_ok, last_kill, step, at_edge, land, hit_acc, clr, landed_q, pixel_q;
  int per, hit_idx;
  always_comb begin
    lcol = '0;
    rcol = '0;
    brow = '0;
    armed = '0;
    pix = 1'b0;
    below = 1'b0;
    for (int c = NUM_COLUMNS - 1; c >= 0; c--)
      for (int r = 0; r < NUM_ROWS; r++)
        if (alive[r*NUM_COLUMNS+c]) lcol = 4'(c);
    for (int c = 0; c < NUM_COLUMNS; c++) begin
      below = 1'b0;
      for (int r = NUM_ROWS - 1; r >= 0; r--) begin
        armed[r*NUM_COLUMNS+c] = alive[r*NUM_COLUMNS+c] && !below;
        below = below | alive[r*NUM_COLUMNS+c];
        if (alive[r*NUM_COLUMNS+c]) begin
          rcol = 4'(c);
          brow = (3'(r) > brow) ? 3'(r) : brow;
          if (int'(bus.scan_x) >= int'(fx) + c*SPACING_X && int'(bus.scan_x) < int'(fx) + c*SPACING_X + ALIEN_W &&
              int'(bus.scan_y) >= int'(fy) + r*SPACING_Y && int'(bus.scan_y) < int'(fy) + r*SPACING_Y + ALIEN_H)
            pix = 1'b1;
        end
      end
    end
    per = BASE_PERIOD - 2*int'(lvl) - int'(kills);
    per = (per < MIN_PERIOD) ? MIN_PERIOD : per;
    hit_idx = int'(bus.hit_row) * NUM_COLUMNS + int'(bus.hit_col);
    hit_mask = (int'(bus.hit_row) < NUM_ROWS && int'(bus.hit_col) < NUM_COLUMNS) ? N'(1) << hit_idx : '0;
    hit_ok = state == MARCH && bus.hit_valid && |(alive & hit_mask);
    last_kill = hit_ok && ((alive & ~hit_mask) == '0);
    // >= lets the counter catch up if kills shrink the period below its current count
    step = state == MARCH && bus.frame_tick && int'(cnt) >= per - 1;
    at_edge = dir_left ? (int'(fx) + int'(lcol)*SPACING_X - STEP_X < LEFT_BOUND)
                       : (int'(fx) + int'(rcol)*SPACING_X + ALIEN_W - 1 + STEP_X > RIGHT_BOUND);
    land = int'(fy) + STEP_Y + int'(brow)*SPACING_Y + ALIEN_H >= LAND_Y;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      alive <= '1;
      fx <= 16'(START_X);
      fy <= 16'(START_Y);
      dir_left <= 1'b0;
      cnt <= '0;
      kills <= '0;
      lvl <= '0;
      hit_acc <= 1'b0;
      clr <= 1'b0;
      landed_q <= 1'b0;
      pixel_q <= 1'b0;
    end else begin
      hit_acc <= 1'b0;
      clr <= 1'b0;
      pixel_q <= pix;
      if (bus.start) begin
        state <= MARCH;
        alive <= '1;
        fx <= 16'(START_X);
        fy <= 16'(START_Y);
        dir_left <= 1'b0;
        cnt <= '0;
        kills <= '0;
        landed_q <= 1'b0;
        lvl <= (state == IDLE || state == LANDED) ? 4'd0 : lvl;
      end else if (state == MARCH) begin
        if (hit_ok) begin
          alive <= alive & ~hit_mask;
          kills <= kills + 16'd1;
          hit_acc <= 1'b1;
        end
        if (last_kill) begin
          state <= CLEARED;
          clr <= 1'b1;
          lvl <= (lvl == 4'd15) ? lvl : lvl + 4'd1;
        end else if (bus.frame_tick) begin
          cnt <= step ? 16'd0 : cnt + 16'd1;
          if (step && at_edge) begin
            fy <= fy + 16'(STEP_Y);
            dir_left <= !dir_left;
            if (land) begin
              state <= LANDED;
              landed_q <= 1'b1;
            end
          end else if (step)
            fx <= dir_left ? fx - 16'(STEP_X) : fx + 16'(STEP_X);
        end
      end
    end
  assign bus.alive_matrix = alive;
  assign bus.armed_matrix = armed;
  assign bus.formation_x = fx;
  assign bus.formation_y = fy;
  assign bus.level = lvl;
  assign bus.hit_accept = hit_acc;
  assign bus.cleared = clr;
  assign bus.landed = landed_q;
  assign bus.alien_pixel = pixel_q;
`ifdef ALIEN_FORMATION_SHOOTER_EN
  logic [15:0] lfsr;
  logic [3:0] fcol;
  logic [2:0] frow;
  logic fhas;
  always_comb begin
    fcol = 4'(int'(lfsr) % NUM_COLUMNS);
    frow = '0;
    fhas = 1'b0;
    for (int r = 0; r < NUM_ROWS; r++)
      for (int c = 0; c < NUM_COLUMNS; c++)
        if (c == int'(fcol) && armed[r*NUM_COLUMNS+c]) begin
          frow = 3'(r);
          fhas = 1'b1;
        end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lfsr <= 16'hACE1;
      bus.fire_req <= 1'b0;
      bus.fire_x <= '0;
      bus.fire_y <= '0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      bus.fire_req <= step && !bus.start && !last_kill && fhas;
      bus.fire_x <= 16'(int'(fx) + int'(fcol)*SPACING_X + ALIEN_W/2);
      bus.fire_y <= 16'(int'(fy) + int'(frow)*SPACING_Y + ALIEN_H);
    end
`endif
endmodule
